// File: rtl/cmp_threshold_monitor.sv
// Hysteresis qualifier for a one-hot gt/lt/eq comparator result: debounced alarm
// with rise/fall pulses, saturating per-outcome counters and a sticky malformed-flag error.
module cmp_threshold_monitor #(
    parameter int unsigned TRIP_COUNT  = 3,
    parameter int unsigned CLEAR_COUNT = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic             alarm,
    output logic             trip_pulse,
    output logic             clear_pulse,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic             flag_err
);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_ARMING   = 2'd1,
        ST_TRIPPED  = 2'd2,
        ST_CLEARING = 2'd3
    } state_t;

    localparam logic [7:0]       TRIP_RUN  = 8'(TRIP_COUNT);
    localparam logic [7:0]       CLEAR_RUN = 8'(CLEAR_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state_q, state_d;
    logic [7:0] run_q, run_d, run_inc;
    logic       alarm_q, alarm_d;
    logic       trip_q, trip_d;
    logic       clear_q, clear_d;
    logic       err_q, err_d;
    logic       one_hot, accepted;
    logic [2:0] hit;
    logic [CNT_W-1:0] cnt_out [3];

    always_comb begin
        one_hot  = ({gt, lt, eq} inside {3'b100, 3'b010, 3'b001});
        accepted = in_valid && one_hot;
        hit      = {eq, lt, gt} & {3{accepted && !clr}};
        run_inc  = run_q + 8'd1;

        state_d = state_q;
        run_d   = run_q;
        err_d   = err_q;

        if (clr) begin
            state_d = ST_NORMAL;
            run_d   = 8'd0;
            err_d   = 1'b0;
        end else if (in_valid && !one_hot) begin
            err_d = 1'b1;
        end else if (accepted) begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (gt) begin
                        run_d   = 8'd1;
                        state_d = (TRIP_COUNT == 1) ? ST_TRIPPED : ST_ARMING;
                    end else begin
                        run_d = 8'd0;
                    end
                end
                ST_ARMING: begin
                    if (gt) begin
                        run_d = run_inc;
                        if (run_inc == TRIP_RUN) state_d = ST_TRIPPED;
                    end else if (lt) begin
                        run_d   = 8'd0;
                        state_d = ST_NORMAL;
                    end
                end
                ST_TRIPPED: begin
                    if (lt) begin
                        run_d   = 8'd1;
                        state_d = (CLEAR_COUNT == 1) ? ST_NORMAL : ST_CLEARING;
                    end else begin
                        run_d = 8'd0;
                    end
                end
                ST_CLEARING: begin
                    if (lt) begin
                        run_d = run_inc;
                        if (run_inc == CLEAR_RUN) state_d = ST_NORMAL;
                    end else if (gt) begin
                        run_d   = 8'd0;
                        state_d = ST_TRIPPED;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    run_d   = 8'd0;
                end
            endcase
        end

        // CLEARING->TRIPPED is excluded: the alarm never dropped, so no rise to report.
        alarm_d = (state_d == ST_TRIPPED) || (state_d == ST_CLEARING);
        trip_d  = !clr && (state_d == ST_TRIPPED) &&
                  ((state_q == ST_NORMAL) || (state_q == ST_ARMING));
        clear_d = !clr && (state_d == ST_NORMAL) &&
                  ((state_q == ST_TRIPPED) || (state_q == ST_CLEARING));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            run_q   <= 8'd0;
            alarm_q <= 1'b0;
            trip_q  <= 1'b0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            trip_q  <= trip_d;
            clear_q <= clear_d;
            err_q   <= err_d;
        end
    end

    // Counter index: 0 = gt, 1 = lt, 2 = eq.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (hit[gi] && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_out[gi] = cnt_q;
        end
    endgenerate

    assign alarm       = alarm_q;
    assign trip_pulse  = trip_q;
    assign clear_pulse = clear_q;
    assign flag_err    = err_q;
    assign gt_cnt      = cnt_out[0];
    assign lt_cnt      = cnt_out[1];
    assign eq_cnt      = cnt_out[2];

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Scoreboard bench for cmp_threshold_monitor: directed samples push hand-computed
// expectations; a monitor pops and compares one entry after each clock edge.
module tb_cmp_threshold_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       gt = 1'b0;
    logic       lt = 1'b0;
    logic       eq = 1'b0;

    logic       alarm, trip_pulse, clear_pulse, flag_err;
    logic [7:0] gt_cnt, lt_cnt, eq_cnt;

    logic       alarm4, trip4, clear4, err4;
    logic [3:0] gt_cnt4, lt_cnt4, eq_cnt4;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      name;
        logic       a, tp, cp, err;
        logic [7:0] gc, lc, ec;
        logic [3:0] e4;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    cmp_threshold_monitor #(.TRIP_COUNT(3), .CLEAR_COUNT(2), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .gt(gt), .lt(lt), .eq(eq),
        .alarm(alarm), .trip_pulse(trip_pulse), .clear_pulse(clear_pulse),
        .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .flag_err(flag_err)
    );

    // Narrow-counter instance on the same stimulus, used for the saturation check.
    cmp_threshold_monitor #(.TRIP_COUNT(3), .CLEAR_COUNT(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .gt(gt), .lt(lt), .eq(eq),
        .alarm(alarm4), .trip_pulse(trip4), .clear_pulse(clear4),
        .gt_cnt(gt_cnt4), .lt_cnt(lt_cnt4), .eq_cnt(eq_cnt4), .flag_err(err4)
    );

    task automatic step(input string nm, input logic v, g, l, e, c,
                        input logic a, tp, cp, err,
                        input int gc, lc, ec, e4);
        exp_t x;
        @(negedge clk);
        in_valid = v; gt = g; lt = l; eq = e; clr = c;
        x.name = nm; x.a = a; x.tp = tp; x.cp = cp; x.err = err;
        x.gc = 8'(gc); x.lc = 8'(lc); x.ec = 8'(ec); x.e4 = 4'(e4);
        exp_q.push_back(x);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; gt = 1'b0; lt = 1'b0; eq = 1'b0; clr = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        tests++;
        if ({alarm, trip_pulse, clear_pulse, flag_err} !== 4'b0 ||
            gt_cnt !== 8'd0 || lt_cnt !== 8'd0 || eq_cnt !== 8'd0 || eq_cnt4 !== 4'd0) begin
            fails++;
            $display("[TB] FAIL %s: got a/tp/cp/err=%b%b%b%b gt=%0d lt=%0d eq=%0d eq4=%0d, want all 0",
                     nm, alarm, trip_pulse, clear_pulse, flag_err, gt_cnt, lt_cnt, eq_cnt, eq_cnt4);
        end else begin
            $display("[TB] %s ok", nm);
        end
    endtask

    // Monitor: outputs are sampled 2 time units after each rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tests++;
                if (alarm !== x.a || trip_pulse !== x.tp || clear_pulse !== x.cp ||
                    flag_err !== x.err || gt_cnt !== x.gc || lt_cnt !== x.lc ||
                    eq_cnt !== x.ec || eq_cnt4 !== x.e4) begin
                    fails++;
                    $display("[TB] FAIL %s: got a/tp/cp/err=%b%b%b%b gt=%0d lt=%0d eq=%0d eq4=%0d, want %b%b%b%b gt=%0d lt=%0d eq=%0d eq4=%0d",
                             x.name, alarm, trip_pulse, clear_pulse, flag_err,
                             gt_cnt, lt_cnt, eq_cnt, eq_cnt4,
                             x.a, x.tp, x.cp, x.err, x.gc, x.lc, x.ec, x.e4);
                end else begin
                    $display("[TB] %s ok: alarm=%b gt=%0d lt=%0d eq=%0d", x.name, alarm, gt_cnt, lt_cnt, eq_cnt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //   name          v  g  l  e  c   a  tp cp er  gc lc ec e4
        step("trip_gt1",   1, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0);
        step("trip_gt2",   1, 1, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0, 0);
        step("trip_gt3",   1, 1, 0, 0, 0,  1, 1, 0, 0,  3, 0, 0, 0);
        step("trip_idle",  0, 1, 0, 0, 0,  1, 0, 0, 0,  3, 0, 0, 0);
        step("clr_lt1",    1, 0, 1, 0, 0,  1, 0, 0, 0,  3, 1, 0, 0);
        step("clr_back_gt",1, 1, 0, 0, 0,  1, 0, 0, 0,  4, 1, 0, 0);
        step("clr_lt2",    1, 0, 1, 0, 0,  1, 0, 0, 0,  4, 2, 0, 0);
        step("clr_lt3",    1, 0, 1, 0, 0,  0, 0, 1, 0,  4, 3, 0, 0);
        step("clr_idle",   0, 0, 0, 0, 0,  0, 0, 0, 0,  4, 3, 0, 0);
        step("eqh_gt1",    1, 1, 0, 0, 0,  0, 0, 0, 0,  5, 3, 0, 0);
        step("eqh_gt2",    1, 1, 0, 0, 0,  0, 0, 0, 0,  6, 3, 0, 0);
        step("eqh_eq",     1, 0, 0, 1, 0,  0, 0, 0, 0,  6, 3, 1, 1);
        step("eqh_gt3",    1, 1, 0, 0, 0,  1, 1, 0, 0,  7, 3, 1, 1);
        step("bad_gt_lt",  1, 1, 1, 0, 0,  1, 0, 0, 1,  7, 3, 1, 1);
        step("bad_none",   1, 0, 0, 0, 0,  1, 0, 0, 1,  7, 3, 1, 1);
        step("clr_drop",   1, 1, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0);
        step("post_clr_gt",1, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step($sformatf("sat_eq%0d", i), 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, i, (i > 15) ? 15 : i);
        end
        step("pre_rst_clr",1, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0);
        step("pre_rst_gt1",1, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0);
        step("pre_rst_gt2",1, 1, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0, 0);

        // Drop reset between edges; outputs must clear without a clock.
        @(posedge clk);
        #3;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step("post_rst_gt1",1, 1, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0);
        step("post_rst_gt2",1, 1, 0, 0, 0,  0, 0, 0, 0,  2, 0, 0, 0);
        step("post_rst_gt3",1, 1, 0, 0, 0,  1, 1, 0, 0,  3, 0, 0, 0);
        step("arm_lt_norm", 1, 0, 1, 0, 0,  1, 0, 0, 0,  3, 1, 0, 0);
        @(negedge clk);
        idle_inputs();

        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
